// File: rtl/arm_pkg.sv
// Shared types and encodings for the single-cycle ARMv4-subset system.
package arm_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 4;
    localparam int unsigned NUM_GPR = 15;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [REG_AW-1:0] REG_PC = 4'hF;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef enum logic [1:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR
    } alu_ctrl_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // NV (1111) is treated as never-execute
    function automatic logic cond_pass(input cond_e cond, input flags_t f);
        case (cond)
            COND_EQ: cond_pass = f.z;
            COND_NE: cond_pass = !f.z;
            COND_CS: cond_pass = f.c;
            COND_CC: cond_pass = !f.c;
            COND_MI: cond_pass = f.n;
            COND_PL: cond_pass = !f.n;
            COND_VS: cond_pass = f.v;
            COND_VC: cond_pass = !f.v;
            COND_HI: cond_pass = f.c && !f.z;
            COND_LS: cond_pass = !f.c || f.z;
            COND_GE: cond_pass = (f.n == f.v);
            COND_LT: cond_pass = (f.n != f.v);
            COND_GT: cond_pass = !f.z && (f.n == f.v);
            COND_LE: cond_pass = f.z || (f.n != f.v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_core.sv
// Single-cycle ARMv4-subset core: decode, condition check, PC and flags,
// plus the datapath (register file, ALU, writeback mux).
module arm_core
    import arm_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_read_data,
    output logic [XLEN-1:0] o_pc,
    output logic            o_mem_write_c,
    output logic [XLEN-1:0] o_alu_result_c,
    output logic [XLEN-1:0] o_write_data_c
);

    logic [XLEN-1:0]   PC;
    logic [XLEN-1:0]   Instr;
    logic [XLEN-1:0]   w_pc8;
    logic [XLEN-1:0]   w_pc_next;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_result;
    flags_t            r_flags;
    flags_t            w_flags_next;
    flags_t            w_alu_flags;
    alu_ctrl_e         w_alu_ctrl;
    logic              w_valid;
    logic              w_src_imm;
    logic              w_set_flags;
    logic              w_reg_write;
    logic              w_mem_store;
    logic              w_mem_load;
    logic              w_branch;
    logic              w_exec;
    logic              w_rd_is_pc;
    logic [1:0]        w_op;
    logic [3:0]        w_cmd;
    logic [REG_AW-1:0] w_rn;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rm;
    logic [REG_AW-1:0] w_ra2;

    assign Instr      = i_instr;
    assign w_op       = Instr[27:26];
    assign w_cmd      = Instr[24:21];
    assign w_rn       = Instr[19:16];
    assign w_rd       = Instr[15:12];
    assign w_rm       = Instr[3:0];
    assign w_pc8      = PC + XLEN'(8);
    assign w_rd_is_pc = (w_rd == REG_PC);

    // Decode; anything outside the supported subset leaves w_valid low
    always_comb begin
        w_valid     = 1'b0;
        w_src_imm   = 1'b0;
        w_set_flags = 1'b0;
        w_reg_write = 1'b0;
        w_mem_store = 1'b0;
        w_mem_load  = 1'b0;
        w_branch    = 1'b0;
        w_alu_ctrl  = ALU_ADD;
        w_imm       = '0;
        case (w_op)
            OP_DP: begin
                w_src_imm   = Instr[25];
                w_imm       = XLEN'(Instr[7:0]);
                w_set_flags = Instr[20];
                w_reg_write = 1'b1;
                w_valid     = Instr[25] ? (Instr[11:8] == 4'h0) : (Instr[11:4] == 8'h00);
                case (w_cmd)
                    CMD_ADD: w_alu_ctrl = ALU_ADD;
                    CMD_SUB: w_alu_ctrl = ALU_SUB;
                    CMD_AND: w_alu_ctrl = ALU_AND;
                    CMD_ORR: w_alu_ctrl = ALU_ORR;
                    default: w_valid    = 1'b0;
                endcase
            end
            OP_MEM: begin
                // immediate, pre-indexed, up, word, no writeback
                w_valid     = (Instr[25:21] == 5'b01100);
                w_src_imm   = 1'b1;
                w_imm       = XLEN'(Instr[11:0]);
                w_mem_load  = Instr[20];
                w_mem_store = !Instr[20];
                w_reg_write = Instr[20];
            end
            OP_BR: begin
                w_valid  = (Instr[25:24] == 2'b10);
                w_branch = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_exec        = w_valid && cond_pass(cond_e'(Instr[31:28]), r_flags);
    assign w_ra2         = (w_mem_store || w_mem_load) ? w_rd : w_rm;
    assign o_mem_write_c = w_exec && w_mem_store && i_rst_n;

    always_comb begin
        w_pc_next = PC + XLEN'(4);
        if (w_exec && w_branch)
            w_pc_next = w_pc8 + {{6{Instr[23]}}, Instr[23:0], 2'b00};
        else if (w_exec && w_reg_write && w_rd_is_pc)
            w_pc_next = w_result;
    end

    // Logical ops leave C and V untouched (no shifter carry-out in this subset)
    always_comb begin
        w_flags_next = r_flags;
        if (w_exec && w_set_flags) begin
            w_flags_next.n = w_alu_flags.n;
            w_flags_next.z = w_alu_flags.z;
            if (w_alu_ctrl == ALU_ADD || w_alu_ctrl == ALU_SUB) begin
                w_flags_next.c = w_alu_flags.c;
                w_flags_next.v = w_alu_flags.v;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            PC      <= '0;
            r_flags <= '0;
        end else begin
            PC      <= w_pc_next;
            r_flags <= w_flags_next;
        end
    end

    assign o_pc = PC;

    arm_datapath u_datapathdp (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_pc8          (w_pc8),
        .i_ra1          (w_rn),
        .i_ra2          (w_ra2),
        .i_wa           (w_rd),
        .i_reg_write    (w_exec && w_reg_write && !w_rd_is_pc),
        .i_src_imm      (w_src_imm),
        .i_mem_to_reg   (w_mem_load),
        .i_imm          (w_imm),
        .i_alu_ctrl     (w_alu_ctrl),
        .i_read_data    (i_read_data),
        .o_alu_result_c (o_alu_result_c),
        .o_write_data_c (o_write_data_c),
        .o_result_c     (w_result),
        .o_alu_flags_c  (w_alu_flags)
    );

endmodule

// Register file R0-R14 (R15 reads as PC+8), operand select, ALU and writeback.
module arm_datapath
    import arm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [XLEN-1:0]   i_pc8,
    input  logic [REG_AW-1:0] i_ra1,
    input  logic [REG_AW-1:0] i_ra2,
    input  logic [REG_AW-1:0] i_wa,
    input  logic              i_reg_write,
    input  logic              i_src_imm,
    input  logic              i_mem_to_reg,
    input  logic [XLEN-1:0]   i_imm,
    input  alu_ctrl_e         i_alu_ctrl,
    input  logic [XLEN-1:0]   i_read_data,
    output logic [XLEN-1:0]   o_alu_result_c,
    output logic [XLEN-1:0]   o_write_data_c,
    output logic [XLEN-1:0]   o_result_c,
    output flags_t            o_alu_flags_c
);

    logic [XLEN-1:0] r_rf [NUM_GPR];
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [XLEN-1:0] WriteData;
    logic [XLEN-1:0] w_b_eff;
    logic [XLEN-1:0] w_alu;
    logic [XLEN:0]   w_sum;
    logic            w_sub;

    assign SrcA      = (i_ra1 == REG_PC) ? i_pc8 : r_rf[i_ra1];
    assign WriteData = (i_ra2 == REG_PC) ? i_pc8 : r_rf[i_ra2];
    assign SrcB      = i_src_imm ? i_imm : WriteData;

    // Subtract as A + ~B + 1 so carry-out is ARM's NOT-borrow
    assign w_sub   = (i_alu_ctrl == ALU_SUB);
    assign w_b_eff = w_sub ? ~SrcB : SrcB;
    assign w_sum   = {1'b0, SrcA} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, w_sub};

    always_comb begin
        w_alu = w_sum[XLEN-1:0];
        case (i_alu_ctrl)
            ALU_AND: w_alu = SrcA & SrcB;
            ALU_ORR: w_alu = SrcA | SrcB;
            default: w_alu = w_sum[XLEN-1:0];
        endcase
    end

    assign o_alu_flags_c.n = w_alu[XLEN-1];
    assign o_alu_flags_c.z = (w_alu == '0);
    assign o_alu_flags_c.c = w_sum[XLEN];
    assign o_alu_flags_c.v = (SrcA[XLEN-1] == w_b_eff[XLEN-1]) && (w_sum[XLEN-1] != SrcA[XLEN-1]);

    assign o_alu_result_c = w_alu;
    assign o_write_data_c = WriteData;
    assign o_result_c     = i_mem_to_reg ? i_read_data : w_alu;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_GPR; i++) r_rf[i] <= '0;
        end else if (i_reg_write) begin
            r_rf[i_wa] <= o_result_c;
        end
    end

endmodule

// File: rtl/arm_single_cycle_system.sv
// System top: ARM core with a preloaded instruction ROM and a data RAM;
// exposes the data-memory write bus.
module arm_single_cycle_system
    import arm_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] WriteData,
    output logic [XLEN-1:0] DataAdr,
    output logic            MemWrite
);

    localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
    localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

    // Boot program: store 7 to 100, load it back, loop to the store
    logic [XLEN-1:0] r_imem [IMEM_WORDS] = '{
        0: 32'hE040_0000,
        1: 32'hE280_1007,
        2: 32'hE580_1064,
        3: 32'hE590_2064,
        4: 32'hEAFF_FFFC,
        default: '0
    };
    logic [XLEN-1:0] r_dmem [DMEM_WORDS];

    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_instr;
    logic [XLEN-1:0] w_read_data;
    logic            w_unused_pc;

    assign w_instr     = r_imem[w_pc[IMEM_AW+1:2]];
    assign w_read_data = r_dmem[DataAdr[DMEM_AW+1:2]];
    assign w_unused_pc = ^{w_pc[XLEN-1:IMEM_AW+2], w_pc[1:0]};

    always_ff @(posedge clk) begin
        if (MemWrite) r_dmem[DataAdr[DMEM_AW+1:2]] <= WriteData;
    end

    arm_core arm (
        .i_clk          (clk),
        .i_rst_n        (reset),
        .i_instr        (w_instr),
        .i_read_data    (w_read_data),
        .o_pc           (w_pc),
        .o_mem_write_c  (MemWrite),
        .o_alu_result_c (DataAdr),
        .o_write_data_c (WriteData)
    );

endmodule

// File: tb/tb_arm_single_cycle_system.sv
// Directed bench for arm_single_cycle_system: boot program, store/load loop,
// asynchronous mid-loop reset and a conditional-execution program.
module tb_arm_single_cycle_system;

    logic        clk;
    logic        reset;
    logic [31:0] WriteData;
    logic [31:0] DataAdr;
    logic        MemWrite;

    int n_checks = 0;
    int n_errors = 0;

    arm_single_cycle_system dut (
        .clk       (clk),
        .reset     (reset),
        .WriteData (WriteData),
        .DataAdr   (DataAdr),
        .MemWrite  (MemWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc;
        int          pulses;
        int          found;

        // Reset held for two cycles
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_pc",    dut.arm.PC, 32'h0);
        check("rst_instr", dut.arm.Instr, 32'hE040_0000);
        check("rst_mw",    32'(MemWrite), 32'h0);
        check("rst_adr",   DataAdr, 32'h0);
        check("rst_wd",    WriteData, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_mw", 32'(MemWrite), 32'h0);
            check("rst_hold_pc", dut.arm.PC, 32'h0);
        end

        // Boot sequence
        reset = 1'b1;
        #1;
        check("c0_instr", dut.arm.Instr, 32'hE040_0000);
        @(negedge clk);
        check("c1_instr", dut.arm.Instr, 32'hE280_1007);
        check("c1_pc",    dut.arm.PC, 32'h4);
        check("c1_adr",   DataAdr, 32'd7);
        @(negedge clk);
        check("c2_instr", dut.arm.Instr, 32'hE580_1064);
        check("c2_mw",    32'(MemWrite), 32'h1);
        check("c2_adr",   DataAdr, 32'd100);
        check("c2_wd",    WriteData, 32'd7);
        check("c2_srca",  dut.arm.u_datapathdp.SrcA, 32'h0);
        @(negedge clk);
        check("c3_instr", dut.arm.Instr, 32'hE590_2064);
        check("c3_mw",    32'(MemWrite), 32'h0);
        check("c3_adr",   DataAdr, 32'd100);
        @(negedge clk);
        check("c4_instr", dut.arm.Instr, 32'hEAFF_FFFC);
        check("c4_pc",    dut.arm.PC, 32'h10);
        check("c4_r2",    dut.arm.u_datapathdp.r_rf[2], 32'd7);
        check("c4_mw",    32'(MemWrite), 32'h0);
        @(negedge clk);

        // STR/LDR/B loop for 50 cycles starting at 0x08
        exp_pc = 32'h8;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            check("loop_pc", dut.arm.PC, exp_pc);
            check("loop_mw", 32'(MemWrite), 32'(exp_pc == 32'h8));
            if (MemWrite) begin
                pulses++;
                check("loop_adr", DataAdr, 32'd100);
                check("loop_wd",  WriteData, 32'd7);
            end
            exp_pc = (exp_pc == 32'h10) ? 32'h8 : exp_pc + 32'h4;
            @(negedge clk);
        end
        check("loop_pulses", 32'(pulses), 32'd17);

        // Asynchronous reset while a STR is executing
        found = 0;
        for (int k = 0; k < 6 && found == 0; k++) begin
            if (dut.arm.PC == 32'h8) found = 1;
            else @(negedge clk);
        end
        check("wait_str", 32'(found), 32'd1);
        check("pre_rst_mw", 32'(MemWrite), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("arst_pc",    dut.arm.PC, 32'h0);
        check("arst_mw",    32'(MemWrite), 32'h0);
        check("arst_adr",   DataAdr, 32'h0);
        check("arst_r1",    dut.arm.u_datapathdp.r_rf[1], 32'h0);
        check("arst_flags", {28'd0, dut.arm.r_flags}, 32'h0);
        dut.r_dmem[25] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("arst_hold_pc", dut.arm.PC, 32'h0);
        check("arst_ram",     dut.r_dmem[25], 32'hDEAD_BEEF);

        // Restart after release
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rs0_instr", dut.arm.Instr, 32'hE040_0000);
        @(negedge clk);
        check("rs1_pc", dut.arm.PC, 32'h4);
        @(negedge clk);
        check("rs2_pc", dut.arm.PC, 32'h8);
        check("rs2_mw", 32'(MemWrite), 32'h1);
        check("rs2_wd", WriteData, 32'd7);
        @(negedge clk);
        check("rs3_ram", dut.r_dmem[25], 32'd7);

        // Conditional program: SUBS R3,R0,R0 ; ADDNE R4,R0,#1 ; BEQ 0x20
        reset = 1'b0;
        dut.r_imem[0] = 32'hE050_3000;
        dut.r_imem[1] = 32'h1280_4001;
        dut.r_imem[2] = 32'h0A00_0004;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("cp0_instr", dut.arm.Instr, 32'hE050_3000);
        @(negedge clk);
        check("cp1_flags", {28'd0, dut.arm.r_flags}, 32'h6);
        check("cp1_instr", dut.arm.Instr, 32'h1280_4001);
        check("cp1_mw",    32'(MemWrite), 32'h0);
        @(negedge clk);
        check("cp2_r4",    dut.arm.u_datapathdp.r_rf[4], 32'h0);
        check("cp2_pc",    dut.arm.PC, 32'h8);
        check("cp2_instr", dut.arm.Instr, 32'h0A00_0004);
        @(negedge clk);
        check("cp3_pc",    dut.arm.PC, 32'h20);
        check("cp3_instr", dut.arm.Instr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
